// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: bundles every signal between the ALU result stage and
// the logic around it.
//   in_*     ALU result, destination tag and handshake (producer -> stage)
//   out_*    head of the in-order result queue (stage -> register file)
//   flag_*   committed architectural flags
//   br_*     branch condition code in, evaluated result out
// Modports: slave = the stage, master = the surrounding environment.
interface alu_result_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_value;
   logic              in_carry;
   logic              in_zero;
   logic              in_msb;
   logic              in_setflags;
   logic              in_wen;
   logic [REG_AW-1:0] in_rd;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_value;
   logic [REG_AW-1:0] out_rd;
   logic              out_wen;
   logic              flag_carry;
   logic              flag_zero;
   logic              flag_sign;
   logic [2:0]        br_cond;
   logic              br_taken;

   modport slave (
      input  in_valid, in_value, in_carry, in_zero, in_msb, in_setflags, in_wen, in_rd,
      output in_ready,
      output out_valid, out_value, out_rd, out_wen,
      input  out_ready,
      output flag_carry, flag_zero, flag_sign,
      input  br_cond,
      output br_taken
   );

   modport master (
      output in_valid, in_value, in_carry, in_zero, in_msb, in_setflags, in_wen, in_rd,
      input  in_ready,
      input  out_valid, out_value, out_rd, out_wen,
      output out_ready,
      input  flag_carry, flag_zero, flag_sign,
      output br_cond,
      input  br_taken
   );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-to-writeback stage after the ALU.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_result_stage_if.slave: ALU result in (valid/ready), 2-entry in-order
//        FIFO head out toward the register file (valid/ready), committed flags,
//        and branch condition evaluation on those flags.
module alu_result_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input logic               clk,
   input logic               rst,
   alu_result_stage_if.slave bus
);

   logic [DATA_W-1:0] value_q [2];
   logic [DATA_W-1:0] value_d [2];
   logic [REG_AW-1:0] rd_q    [2];
   logic [REG_AW-1:0] rd_d    [2];
   logic [1:0]        wen_q;
   logic [1:0]        wen_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              flag_carry_q, flag_carry_d;
   logic              flag_zero_q, flag_zero_d;
   logic              flag_sign_q, flag_sign_d;

   logic in_ready;
   logic out_valid;
   logic push;
   logic pop;

   // Both handshake flags come from registered state only.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = bus.in_valid & in_ready;
   assign pop       = out_valid & bus.out_ready;

   always_comb begin
      value_d      = value_q;
      rd_d         = rd_q;
      wen_d        = wen_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      flag_carry_d = flag_carry_q;
      flag_zero_d  = flag_zero_q;
      flag_sign_d  = flag_sign_q;

      if (push) begin
         value_d[wr_ptr_q] = bus.in_value;
         rd_d[wr_ptr_q]    = bus.in_rd;
         wen_d[wr_ptr_q]   = bus.in_wen;
         wr_ptr_d          = ~wr_ptr_q;
         // Flag load follows the accept alone, regardless of queue state.
         if (bus.in_setflags) begin
            flag_carry_d = bus.in_carry;
            flag_zero_d  = bus.in_zero;
            flag_sign_d  = bus.in_msb;
         end
      end

      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            value_q[i] <= '0;
            rd_q[i]    <= '0;
         end
         wen_q        <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         flag_carry_q <= 1'b0;
         flag_zero_q  <= 1'b0;
         flag_sign_q  <= 1'b0;
      end else begin
         value_q      <= value_d;
         rd_q         <= rd_d;
         wen_q        <= wen_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         flag_carry_q <= flag_carry_d;
         flag_zero_q  <= flag_zero_d;
         flag_sign_q  <= flag_sign_d;
      end
   end

   logic br_taken;

   always_comb begin
      br_taken = 1'b0;
      case (bus.br_cond)
         3'b000:  br_taken = 1'b0;
         3'b001:  br_taken = 1'b1;
         3'b010:  br_taken = flag_zero_q;
         3'b011:  br_taken = ~flag_zero_q;
         3'b100:  br_taken = flag_carry_q;
         3'b101:  br_taken = ~flag_carry_q;
         3'b110:  br_taken = flag_sign_q;
         3'b111:  br_taken = ~flag_sign_q;
         default: br_taken = 1'b0;
      endcase
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_value  = value_q[rd_ptr_q];
   assign bus.out_rd     = rd_q[rd_ptr_q];
   assign bus.out_wen    = wen_q[rd_ptr_q] & out_valid;
   assign bus.flag_carry = flag_carry_q;
   assign bus.flag_zero  = flag_zero_q;
   assign bus.flag_sign  = flag_sign_q;
   assign bus.br_taken   = br_taken;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for alu_result_stage. Accepts seen on the
// input side push an expected entry; the head of the queue is compared against
// the DUT every cycle it is valid. A flags model checks flag_* and br_taken.
module tb_alu_result_stage;

   typedef struct packed {
      logic [31:0] value;
      logic [4:0]  rd;
      logic        wen;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_result_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   alu_result_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   logic m_carry = 1'b0;
   logic m_zero  = 1'b0;
   logic m_sign  = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic br_model(input logic [2:0] cc, input logic c, input logic z,
                                     input logic s);
      case (cc)
         3'd0:    return 1'b0;
         3'd1:    return 1'b1;
         3'd2:    return z;
         3'd3:    return ~z;
         3'd4:    return c;
         3'd5:    return ~c;
         3'd6:    return s;
         default: return ~s;
      endcase
   endfunction

   // Monitor: sample mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_carry = 1'b0;
         m_zero  = 1'b0;
         m_sign  = 1'b0;
      end else begin
         check_eq("in_ready", 64'(bus.in_ready), 64'(sb.size() != 2));
         check_eq("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
         check_eq("flags", {61'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign},
                  {61'd0, m_carry, m_zero, m_sign});
         check_eq("br_taken", 64'(bus.br_taken),
                  64'(br_model(bus.br_cond, m_carry, m_zero, m_sign)));
         if (sb.size() != 0) begin
            check_eq("head", {26'd0, bus.out_value, bus.out_rd, bus.out_wen},
                     {26'd0, sb[0].value, sb[0].rd, sb[0].wen & bus.out_valid});
            if (bus.out_valid && bus.out_ready) void'(sb.pop_front());
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{value: bus.in_value, rd: bus.in_rd, wen: bus.in_wen});
            if (bus.in_setflags) begin
               m_carry = bus.in_carry;
               m_zero  = bus.in_zero;
               m_sign  = bus.in_msb;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] v, input logic [4:0] rd, input logic wen,
                        input logic sf, input logic c, input logic z, input logic m);
      bus.in_valid    = 1'b1;
      bus.in_value    = v;
      bus.in_rd       = rd;
      bus.in_wen      = wen;
      bus.in_setflags = sf;
      bus.in_carry    = c;
      bus.in_zero     = z;
      bus.in_msb      = m;
   endtask

   task automatic idle();
      bus.in_valid    = 1'b0;
      bus.in_setflags = 1'b0;
   endtask

   task automatic check_br(input logic [2:0] cc, input logic exp);
      bus.br_cond = cc;
      #1;
      check_eq("br_cond", 64'(bus.br_taken), 64'(exp));
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_value    = '0;
      bus.in_rd       = '0;
      bus.in_wen      = 1'b0;
      bus.in_setflags = 1'b0;
      bus.in_carry    = 1'b0;
      bus.in_zero     = 1'b0;
      bus.in_msb      = 1'b0;
      bus.out_ready   = 1'b0;
      bus.br_cond     = 3'd0;

      // Reset state
      cycle();
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_out_value", 64'(bus.out_value), 64'd0);
      check_eq("rst_out_rd", 64'(bus.out_rd), 64'd0);
      check_eq("rst_out_wen", 64'(bus.out_wen), 64'd0);
      for (int i = 0; i < 8; i++) begin
         bus.br_cond = 3'(i);
         #1;
         check_eq("rst_br", 64'(bus.br_taken), 64'(i % 2 == 1));
      end
      cycle();
      rst = 1'b0;

      // Single pass
      bus.out_ready = 1'b1;
      cycle();
      drive(32'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      idle();
      check_eq("sp_value", 64'(bus.out_value), 64'd3);
      check_eq("sp_rd", 64'(bus.out_rd), 64'd4);
      check_eq("sp_wen", 64'(bus.out_wen), 64'd1);
      check_eq("sp_zero", 64'(bus.flag_zero), 64'd0);
      check_br(3'b011, 1'b1);
      cycle();
      check_eq("sp_drained", 64'(bus.out_valid), 64'd0);

      // Full / backpressure
      bus.out_ready = 1'b0;
      drive(32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      check_eq("bp_ready1", 64'(bus.in_ready), 64'd1);
      drive(32'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      idle();
      check_eq("bp_full", 64'(bus.in_ready), 64'd0);
      check_eq("bp_head1", 64'(bus.out_value), 64'd1);
      cycle();
      check_eq("bp_hold", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      cycle();
      check_eq("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
      check_eq("bp_head2", 64'(bus.out_value), 64'd2);
      cycle();
      check_eq("bp_empty", 64'(bus.out_valid), 64'd0);

      // Streaming at count 1
      drive(32'd10, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      check_eq("st_10", 64'(bus.out_value), 64'd10);
      drive(32'd11, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      check_eq("st_11", 64'(bus.out_value), 64'd11);
      check_eq("st_ready", 64'(bus.in_ready), 64'd1);
      drive(32'd12, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      idle();
      check_eq("st_12", 64'(bus.out_value), 64'd12);
      cycle();
      check_eq("st_empty", 64'(bus.out_valid), 64'd0);

      // Flags
      drive(32'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      check_eq("fl_zero_next", 64'(bus.flag_zero), 64'd1);
      drive(32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      idle();
      check_eq("fl_z", 64'(bus.flag_zero), 64'd1);
      check_eq("fl_c", 64'(bus.flag_carry), 64'd1);
      check_eq("fl_s", 64'(bus.flag_sign), 64'd0);
      check_br(3'b010, 1'b1);
      check_br(3'b100, 1'b1);
      check_br(3'b110, 1'b0);
      cycle();

      // wen = 0 entry between neighbours
      bus.out_ready = 1'b0;
      drive(32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      drive(32'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      idle();
      check_eq("wn_head5", 64'(bus.out_value), 64'd5);
      bus.out_ready = 1'b1;
      cycle();
      check_eq("wn_head7", 64'(bus.out_value), 64'd7);
      check_eq("wn_valid", 64'(bus.out_valid), 64'd1);
      check_eq("wn_wen0", 64'(bus.out_wen), 64'd0);
      drive(32'd9, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      idle();
      check_eq("wn_head9", 64'(bus.out_value), 64'd9);
      check_eq("wn_wen1", 64'(bus.out_wen), 64'd1);
      cycle();

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.br_cond   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) != 0)
            drive($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
         else
            idle();
         cycle();
      end
      idle();
      bus.out_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      check_eq("rnd_drained", 64'(sb.size()), 64'd0);

      // Reset mid-stream with two entries queued and flags set
      bus.out_ready = 1'b0;
      drive(32'd20, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle();
      drive(32'd21, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      idle();
      check_eq("mr_full", 64'(bus.in_ready), 64'd0);
      check_eq("mr_sign_set", 64'(bus.flag_sign), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check_eq("mr_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("mr_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("mr_flags", {61'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 64'd0);
      cycle();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("mr_after", 64'(bus.out_valid), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
